// File: rtl/alu_serial_if.sv
// Handshake and data bundle between a requester and the bit-serial ALU sequencer.
// The master issues start/operands/control; the slave returns the result, flags and status.
interface alu_serial_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       control;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output start, A, B, control,
        input  ready, done, out, overflow, zero, negative
    );

    modport slave (
        input  start, A, B, control,
        output ready, done, out, overflow, zero, negative
    );
endinterface

// File: rtl/alu_serial.sv
// Bit-serial ALU sequencer driving alu1 slices LSB first; define ALU_SERIAL_2BIT_EN
// to chain two slices per cycle (WIDTH must then be even).
module alu1 (
    input  logic       a,
    input  logic       b,
    input  logic       carryin,
    input  logic [2:0] control,
    output logic       out,
    output logic       carryout
);
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_NOR = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    logic b_eff;

    always_comb begin
        b_eff    = (control == ALU_SUB) ? ~b : b;
        out      = 1'b0;
        carryout = 1'b0;
        case (control)
            ALU_ADD, ALU_SUB: begin
                out      = a ^ b_eff ^ carryin;
                carryout = (a & b_eff) | (carryin & (a ^ b_eff));
            end
            ALU_AND: out = a & b;
            ALU_OR:  out = a | b;
            ALU_NOR: out = ~(a | b);
            ALU_XOR: out = a ^ b;
            default: out = 1'b0;
        endcase
    end
endmodule

module alu_serial #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    alu_serial_if.slave bus
);
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;

`ifdef ALU_SERIAL_2BIT_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / STEP - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [2:0]       ctrl;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] out_q;
    logic             ready_q;
    logic             done_q;
    logic             overflow_q;
    logic             zero_q;
    logic             negative_q;

    logic [STEP-1:0]  slice_out;
    logic [STEP:0]    chain;
    logic [WIDTH-1:0] res_next;
    logic             is_arith;
    logic             is_illegal;

    // Operands shift right each cycle so the slices always see the low bits;
    // the chain links slice carries, with chain[0] fed from the registered carry.
    assign chain[0] = carry;

    for (genvar i = 0; i < STEP; i++) begin : g_slice
        alu1 u_alu1 (
            .a        (a_sh[i]),
            .b        (b_sh[i]),
            .carryin  (chain[i]),
            .control  (ctrl),
            .out      (slice_out[i]),
            .carryout (chain[i+1])
        );
    end

    assign res_next   = {slice_out, res_sh[WIDTH-1:STEP]};
    assign is_arith   = (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
    assign is_illegal = (ctrl == 3'd0) || (ctrl == 3'd1);

    assign bus.out      = out_q;
    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.zero     = zero_q;
    assign bus.negative = negative_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            ctrl       <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            out_q      <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b1;
            negative_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                    if (bus.start) begin
                        a_sh    <= bus.A;
                        b_sh    <= bus.B;
                        ctrl    <= bus.control;
                        carry   <= (bus.control == ALU_SUB);
                        cnt     <= '0;
                        res_sh  <= '0;
                        ready_q <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> STEP;
                    b_sh   <= b_sh >> STEP;
                    res_sh <= res_next;
                    carry  <= chain[STEP];
                    cnt    <= cnt + 1'b1;
                    // Last group: publish result and flags; overflow uses MSB carry-in/out.
                    if (cnt == LAST) begin
                        state   <= DONE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        if (is_illegal) begin
                            out_q      <= '0;
                            zero_q     <= 1'b1;
                            negative_q <= 1'b0;
                            overflow_q <= 1'b0;
                        end else begin
                            out_q      <= res_next;
                            zero_q     <= (res_next == '0);
                            negative_q <= res_next[WIDTH-1];
                            overflow_q <= is_arith & (chain[STEP-1] ^ chain[STEP]);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_serial.sv
// Directed self-checking bench for alu_serial; latency expectation follows ALU_SERIAL_2BIT_EN.
module tb_alu_serial;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_NOR = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;
`ifdef ALU_SERIAL_2BIT_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 32;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   passed = 0;

    alu_serial_if #(.WIDTH(32)) bus ();

    alu_serial #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] c, output int lat);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.control = c;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #12;
        checks += 6;
        if (bus.ready !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", bus.ready); else passed++;
        if (bus.done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", bus.done); else passed++;
        if (bus.out !== 32'h0) $display("[TB] FAIL reset_out got %h want 0", bus.out); else passed++;
        if (bus.zero !== 1'b1) $display("[TB] FAIL reset_zero got %b want 1", bus.zero); else passed++;
        if (bus.overflow !== 1'b0) $display("[TB] FAIL reset_ovf got %b want 0", bus.overflow); else passed++;
        if (bus.negative !== 1'b0) $display("[TB] FAIL reset_neg got %b want 0", bus.negative); else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_add;
        int lat;
        run_op(32'h5, 32'h3, ALU_ADD, lat);
        checks += 5;
        if (lat !== LAT) $display("[TB] FAIL add_latency got %0d want %0d", lat, LAT); else passed++;
        if (bus.out !== 32'h8) $display("[TB] FAIL add_out got %h want 00000008", bus.out); else passed++;
        if (bus.overflow !== 1'b0) $display("[TB] FAIL add_ovf got %b want 0", bus.overflow); else passed++;
        if (bus.zero !== 1'b0) $display("[TB] FAIL add_zero got %b want 0", bus.zero); else passed++;
        if (bus.negative !== 1'b0) $display("[TB] FAIL add_neg got %b want 0", bus.negative); else passed++;
    endtask

    task automatic test_sub;
        int lat;
        run_op(32'h80000000, 32'h1, ALU_SUB, lat);
        checks += 4;
        if (lat !== LAT) $display("[TB] FAIL sub_latency got %0d want %0d", lat, LAT); else passed++;
        if (bus.out !== 32'h7FFFFFFF) $display("[TB] FAIL sub_ovf_out got %h want 7fffffff", bus.out); else passed++;
        if (bus.overflow !== 1'b1) $display("[TB] FAIL sub_ovf_flag got %b want 1", bus.overflow); else passed++;
        if (bus.negative !== 1'b0) $display("[TB] FAIL sub_ovf_neg got %b want 0", bus.negative); else passed++;
        run_op(32'h5, 32'h5, ALU_SUB, lat);
        checks += 3;
        if (bus.out !== 32'h0) $display("[TB] FAIL sub_eq_out got %h want 0", bus.out); else passed++;
        if (bus.zero !== 1'b1) $display("[TB] FAIL sub_eq_zero got %b want 1", bus.zero); else passed++;
        if (bus.overflow !== 1'b0) $display("[TB] FAIL sub_eq_ovf got %b want 0", bus.overflow); else passed++;
    endtask

    task automatic test_logic;
        logic [2:0]  ops [4] = '{ALU_AND, ALU_OR, ALU_NOR, ALU_XOR};
        logic [31:0] exp [4] = '{32'hF000F000, 32'hFFF0FFF0, 32'h000F000F, 32'h0FF00FF0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(32'hF0F0F0F0, 32'hFF00FF00, ops[i], lat);
            checks += 3;
            if (bus.out !== exp[i]) $display("[TB] FAIL logic_out op%0d got %h want %h", ops[i], bus.out, exp[i]); else passed++;
            if (bus.overflow !== 1'b0) $display("[TB] FAIL logic_ovf op%0d got %b want 0", ops[i], bus.overflow); else passed++;
            if (bus.negative !== exp[i][31]) $display("[TB] FAIL logic_neg op%0d got %b want %b", ops[i], bus.negative, exp[i][31]); else passed++;
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        bus.A = 32'h5; bus.B = 32'h3; bus.control = ALU_ADD; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
            if (i == 5) begin
                bus.A = 32'd100; bus.B = 32'd200; bus.control = ALU_SUB; bus.start = 1'b1;
            end
            if (i == 6) bus.start = 1'b0;
        end
        checks += 2;
        if (lat !== LAT) $display("[TB] FAIL ignore_latency got %0d want %0d", lat, LAT); else passed++;
        if (bus.out !== 32'h8) $display("[TB] FAIL ignore_out got %h want 00000008", bus.out); else passed++;
    endtask

    task automatic test_back_to_back;
        int lat;
        run_op(32'h1, 32'h2, ALU_ADD, lat);
        checks += 2;
        if (bus.out !== 32'h3) $display("[TB] FAIL b2b_first_out got %h want 00000003", bus.out); else passed++;
        if (bus.ready !== 1'b1) $display("[TB] FAIL b2b_done_ready got %b want 1", bus.ready); else passed++;
        bus.A = 32'h7; bus.B = 32'h9; bus.control = ALU_ADD; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        checks += 1;
        if (bus.ready !== 1'b0) $display("[TB] FAIL b2b_accept got ready %b want 0", bus.ready); else passed++;
        wait_done(lat);
        checks += 2;
        if (lat !== LAT) $display("[TB] FAIL b2b_latency got %0d want %0d", lat, LAT); else passed++;
        if (bus.out !== 32'h10) $display("[TB] FAIL b2b_second_out got %h want 00000010", bus.out); else passed++;
    endtask

    task automatic test_illegal;
        int lat;
        run_op(32'h12345678, 32'h1, 3'd1, lat);
        checks += 3;
        if (lat !== LAT) $display("[TB] FAIL illegal_latency got %0d want %0d", lat, LAT); else passed++;
        if (bus.out !== 32'h0) $display("[TB] FAIL illegal_out got %h want 0", bus.out); else passed++;
        if (bus.zero !== 1'b1) $display("[TB] FAIL illegal_zero got %b want 1", bus.zero); else passed++;
    endtask

    task automatic test_reset_mid_run;
        int lat;
        int seen_done;
        run_op(32'h5, 32'h3, ALU_ADD, lat);
        @(negedge clk);
        bus.A = 32'h1; bus.B = 32'h1; bus.control = ALU_ADD; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks += 4;
        if (bus.out !== 32'h0) $display("[TB] FAIL midrst_out got %h want 0", bus.out); else passed++;
        if (bus.zero !== 1'b1) $display("[TB] FAIL midrst_zero got %b want 1", bus.zero); else passed++;
        if (bus.ready !== 1'b1) $display("[TB] FAIL midrst_ready got %b want 1", bus.ready); else passed++;
        if (bus.done !== 1'b0) $display("[TB] FAIL midrst_done got %b want 0", bus.done); else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done++;
        end
        checks += 1;
        if (seen_done !== 0) $display("[TB] FAIL midrst_no_done got %0d pulses want 0", seen_done); else passed++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.control = '0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_ignore_start();
        test_back_to_back();
        test_illegal();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
